random_delay_timer: RTL and testbench
=====================================

// Module: random_delay_timer
// PURPOSE
//  Parametrised random-delay generator for the reaction-timer datapath.
//  - Combines a Fibonacci LFSR (configurable width, tap mask and seed) with a down-counter.
//  - On start, loads a bounded pseudo-random delay and counts it down on tick pulses.
//  - Raises a one-cycle expired pulse at the end; supports one-shot or auto-reload.
//  - Sits between the prescaler (tick source) and the reaction-timer control FSM.
// PARAMETERS
//  WIDTH       12       LFSR width in bits (>=3)
//  TAPS        12'hE08  feedback tap mask; feedback = XOR-reduce(lfsr & TAPS)
//  SEED        12'hAAA  reset and fallback seed; must be nonzero
//  MIN_DELAY   4        minimum delay, in ticks
//  RANGE_MASK  12'h00F  mask applied to the LFSR value to form the random part
//  CNT_W       13       counter width; MIN_DELAY + RANGE_MASK < 2**CNT_W
// PORTS
//  clk        in   1      clock
//  reset      in   1      synchronous, active-high reset
//  lfsr_en    in   1      free-run step enable for the LFSR
//  seed_load  in   1      load LFSR from seed
//  seed       in   WIDTH  seed value; 0 is replaced by SEED
//  start      in   1      arm a new delay (honoured in IDLE only)
//  abort      in   1      cancel the delay in progress
//  tick       in   1      count-enable strobe (one decrement per cycle when high)
//  mode_auto  in   1      1 = reload a new delay after each expiry
//  busy       out  1      state != IDLE
//  expired    out  1      one-cycle pulse, high while state == EXPIRE
//  count      out  CNT_W  remaining ticks
//  rand_out   out  WIDTH  current LFSR value
// BEHAVIOUR
//  Reset (clk, reset synchronous active-high; wins over everything):
//  - lfsr = SEED, state = IDLE, count = 0, busy = 0, expired = 0.
//  LFSR update, per edge, first match wins:
//  - seed_load:              lfsr <= (seed == 0) ? SEED : seed
//  - lfsr_en or load_event:  lfsr <= {lfsr[WIDTH-2:0], ^(lfsr & TAPS)}
//  - A coincident lfsr_en and load_event produce a single step.
//  - The all-zero state is unreachable.
//  Delay load:
//  - load_event = IDLE & start, or EXPIRE & mode_auto & !abort.
//  - Loaded value: delay = MIN_DELAY + (lfsr & RANGE_MASK), using the pre-step lfsr, zero-extended to CNT_W.
//  - If delay == 0, go directly to EXPIRE; otherwise count <= delay and go to COUNT.
//  FSM states: IDLE, COUNT, EXPIRE.
//  - IDLE:   start -> load.
//  - COUNT:  abort -> IDLE with count <= 0 (abort has priority over tick).
//            Else on tick: if count == 1, count <= 0 and go to EXPIRE; else count <= count - 1.
//            Without tick, hold. start is ignored.
//  - EXPIRE: expired = 1 for exactly one cycle.
//            mode_auto & !abort -> load and continue; else -> IDLE.
//            A start input in EXPIRE is ignored.
//  Latency and outputs:
//  - With tick held high, expired rises on the delay-th edge after the load edge.
//  - All outputs are registered or decoded from the state register; there are no combinational paths from inputs.
//  - seed_load during COUNT reseeds the LFSR only; the running count is unaffected.
//  - Reset mid-count returns to IDLE immediately; no expired pulse is produced.
// TESTING
//  1 Reset -> rand_out = 0xAAA, count = 0, busy = 0, expired = 0.
//  2 lfsr_en for 1 cycle after reset -> rand_out = 0x555 (feedback = 1); a second cycle -> 0xAAA ^ ... follows the tap mask (check against a model).
//  3 start with tick = 1 and mode_auto = 0 -> count = 14 (4 + 0xA) and rand_out = 0x555 after the edge;
//    expired is high for 1 cycle on the 14th edge after start; then busy = 0.
//  4 seed_load with seed = 0 -> rand_out = 0xAAA; seed_load with seed = 0x001 -> rand_out = 0x001;
//    a seed_load coincident with lfsr_en loads without stepping.
//  5 start, 5 ticks, then abort coincident with tick -> next cycle IDLE, count = 0, busy = 0, and no expired pulse.
//  6 mode_auto = 1, same flow as test 3 -> after the expiry, count reloads to 9 (4 + (0x555 & 0xF)) with busy held high;
//    asserting abort during that EXPIRE cycle -> IDLE instead of reload.

Source files
------------

// File: rtl/random_delay_timer.sv
// Random-delay timer: a Fibonacci LFSR picks a bounded delay, and a
// down-counter runs it off on tick strobes, then pulses expired_o for one
// cycle. In auto mode a fresh delay is drawn on every expiry.
module random_delay_timer #(
    parameter int               WIDTH      = 12,
    parameter logic [WIDTH-1:0] TAPS       = 12'hE08,
    parameter logic [WIDTH-1:0] SEED       = 12'hAAA,
    parameter int               MIN_DELAY  = 4,
    parameter logic [WIDTH-1:0] RANGE_MASK = 12'h00F,
    parameter int               CNT_W      = 13
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             lfsr_en_i,
    input  logic             seed_load_i,
    input  logic [WIDTH-1:0] seed_i,
    input  logic             start_i,
    input  logic             abort_i,
    input  logic             tick_i,
    input  logic             mode_auto_i,
    output logic             busy_o,
    output logic             expired_o,
    output logic [CNT_W-1:0] count_o,
    output logic [WIDTH-1:0] rand_out_o
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_COUNT  = 2'd1,
        S_EXPIRE = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [WIDTH-1:0] lfsr_q, lfsr_d;

    logic             load;
    logic [WIDTH-1:0] lfsr_step;
    logic [WIDTH-1:0] rand_part;
    logic [CNT_W-1:0] delay;

    // Shift left, feedback into bit 0. A nonzero seed never reaches all-zero.
    assign lfsr_step = {lfsr_q[WIDTH-2:0], ^(lfsr_q & TAPS)};

    // Delay is drawn from the LFSR value before the step that the load causes.
    assign rand_part = lfsr_q & RANGE_MASK;
    assign delay     = CNT_W'(MIN_DELAY) + CNT_W'(rand_part);

    // State, counter and LFSR registers; synchronous reset wins over all.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            count_q <= '0;
            lfsr_q  <= SEED;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            lfsr_q  <= lfsr_d;
        end
    end

    // Next-state, counter and LFSR update logic.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        lfsr_d  = lfsr_q;
        load    = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (start_i) load = 1'b1;
            end
            S_COUNT: begin
                // abort beats tick; start is ignored while counting
                if (abort_i) begin
                    state_d = S_IDLE;
                    count_d = '0;
                end else if (tick_i) begin
                    if (count_q == CNT_W'(1)) begin
                        count_d = '0;
                        state_d = S_EXPIRE;
                    end else begin
                        count_d = count_q - CNT_W'(1);
                    end
                end
            end
            S_EXPIRE: begin
                if (mode_auto_i && !abort_i) load    = 1'b1;
                else                         state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                count_d = '0;
            end
        endcase

        // A zero-length delay skips straight to the expiry pulse.
        if (load) begin
            count_d = delay;
            state_d = (delay == '0) ? S_EXPIRE : S_COUNT;
        end

        // Reseed takes priority; a load and lfsr_en together still step once.
        if (seed_load_i)            lfsr_d = (seed_i == '0) ? SEED : seed_i;
        else if (lfsr_en_i || load) lfsr_d = lfsr_step;
    end

    assign busy_o     = (state_q != S_IDLE);
    assign expired_o  = (state_q == S_EXPIRE);
    assign count_o    = count_q;
    assign rand_out_o = lfsr_q;

endmodule

// File: tb/tb_random_delay_timer.sv
// Directed bench for random_delay_timer with hand-computed expectations.
module tb_random_delay_timer;

    logic        clk = 1'b0;
    logic        reset;
    logic        lfsr_en_i, seed_load_i, start_i, abort_i, tick_i, mode_auto_i;
    logic [11:0] seed_i;
    logic        busy_o, expired_o;
    logic [12:0] count_o;
    logic [11:0] rand_out_o;

    int n_cmp = 0;
    int n_err = 0;

    random_delay_timer dut (
        .clk         (clk),
        .reset       (reset),
        .lfsr_en_i   (lfsr_en_i),
        .seed_load_i (seed_load_i),
        .seed_i      (seed_i),
        .start_i     (start_i),
        .abort_i     (abort_i),
        .tick_i      (tick_i),
        .mode_auto_i (mode_auto_i),
        .busy_o      (busy_o),
        .expired_o   (expired_o),
        .count_o     (count_o),
        .rand_out_o  (rand_out_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one edge; outputs are sampled 1 time unit after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic idle_chk(input string tag);
        check({tag, ".busy"},    32'(busy_o),    32'd0);
        check({tag, ".count"},   32'(count_o),   32'd0);
        check({tag, ".expired"}, 32'(expired_o), 32'd0);
    endtask

    initial begin
        lfsr_en_i = 0; seed_load_i = 0; start_i = 0; abort_i = 0;
        tick_i = 0; mode_auto_i = 0; seed_i = '0; reset = 1'b1;

        // 1: reset state
        do_reset();
        check("rst.rand", 32'(rand_out_o), 32'hAAA);
        idle_chk("rst");

        // 2: free-run LFSR steps: 0xAAA -> 0x555 -> 0xAAB
        lfsr_en_i = 1; step(); lfsr_en_i = 0;
        check("lfsr.step1", 32'(rand_out_o), 32'h555);
        lfsr_en_i = 1; step(); lfsr_en_i = 0;
        check("lfsr.step2", 32'(rand_out_o), 32'hAAB);
        step();
        check("lfsr.hold", 32'(rand_out_o), 32'hAAB);

        // 3: one-shot, tick held high, delay = 4 + 0xA = 14
        do_reset();
        start_i = 1; tick_i = 1; step(); start_i = 0;
        check("os.count0", 32'(count_o),    32'd14);
        check("os.rand",   32'(rand_out_o), 32'h555);
        check("os.busy",   32'(busy_o),     32'd1);
        for (int i = 1; i <= 13; i++) begin
            // start during COUNT must be ignored
            start_i = (i == 5);
            step();
            check($sformatf("os.count%0d", i), 32'(count_o), 32'(14 - i));
            check($sformatf("os.exp%0d", i), 32'(expired_o), 32'd0);
        end
        start_i = 0;
        step();
        check("os.expired", 32'(expired_o), 32'd1);
        check("os.cnt_exp", 32'(count_o),   32'd0);
        step();
        idle_chk("os.done");
        tick_i = 0;

        // 4: seed loading
        seed_load_i = 1; seed_i = 12'h000; step();
        check("seed.zero", 32'(rand_out_o), 32'hAAA);
        seed_i = 12'h001; step();
        check("seed.one", 32'(rand_out_o), 32'h001);
        seed_i = 12'h123; lfsr_en_i = 1; step();
        check("seed.with_en", 32'(rand_out_o), 32'h123);
        seed_load_i = 0; lfsr_en_i = 0; seed_i = '0;

        // 5: reseed mid-count, then abort coincident with tick
        do_reset();
        start_i = 1; step(); start_i = 0;
        check("ab.count0", 32'(count_o), 32'd14);
        seed_load_i = 1; seed_i = 12'h0F0; step(); seed_load_i = 0;
        check("ab.reseed", 32'(rand_out_o), 32'h0F0);
        check("ab.hold",   32'(count_o),    32'd14);
        tick_i = 1;
        for (int i = 0; i < 5; i++) step();
        check("ab.count5", 32'(count_o), 32'd9);
        abort_i = 1; step(); abort_i = 0; tick_i = 0;
        idle_chk("ab.idle");
        tick_i = 1;
        for (int i = 0; i < 12; i++) step();
        check("ab.no_exp", 32'(expired_o), 32'd0);
        tick_i = 0;

        // 6: auto-reload: 14 then 9 (4 + 0x5); abort in second EXPIRE
        do_reset();
        mode_auto_i = 1; start_i = 1; tick_i = 1; step(); start_i = 0;
        check("au.count0", 32'(count_o), 32'd14);
        for (int i = 0; i < 13; i++) step();
        check("au.count1", 32'(count_o), 32'd1);
        step();
        check("au.exp1", 32'(expired_o), 32'd1);
        step();
        check("au.reload", 32'(count_o),    32'd9);
        check("au.busy",   32'(busy_o),     32'd1);
        check("au.noexp",  32'(expired_o),  32'd0);
        check("au.rand",   32'(rand_out_o), 32'hAAB);
        for (int i = 0; i < 8; i++) step();
        check("au.count_last", 32'(count_o), 32'd1);
        step();
        check("au.exp2", 32'(expired_o), 32'd1);
        abort_i = 1; step(); abort_i = 0;
        idle_chk("au.abort");
        check("au.rand_hold", 32'(rand_out_o), 32'hAAB);
        mode_auto_i = 0; tick_i = 0;

        // 7: reset mid-count goes idle with no expiry
        start_i = 1; tick_i = 1; step(); start_i = 0;
        step(); step();
        check("mr.busy", 32'(busy_o), 32'd1);
        reset = 1; step(); reset = 0;
        idle_chk("mr");
        check("mr.rand", 32'(rand_out_o), 32'hAAA);
        tick_i = 0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
